sd_stream_residue_accumulator: RTL and testbench

Sequential, parametrised successor to the three-operand signed-digit adder. Accepts a stream of signed-digit operands (plus/minus vector pairs) over a valid/ready handshake. Accumulates them into a redundant (carry-free) residue, one operand per cycle, in either plain-sum or online-division shift-and-add mode. On the last operand it converts the residue to two's complement and presents the result, sign flag and sticky overflow flag over a second valid/ready handshake.

---
 rtl/sd_stream_residue_accumulator.sv | 119 +++++++++++
 tb/tb_sd_stream_residue_accumulator.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sd_stream_residue_accumulator.sv
// Streams signed-digit operands into a carry-save residue (R+x or 2R+x), then converts once to two's complement.
// Result valid two edges after the last beat; input stalls during convert/hold, result holds until out_ready.
module sd_stream_residue_accumulator #(
  parameter  int BITS  = 64,
  parameter  int GUARD = 4,
  localparam int W     = BITS + GUARD
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  input  logic            acc_mode,
  input  logic [BITS-1:0] x_plus,
  input  logic [BITS-1:0] x_minus,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    result,
  output logic            compare,
  output logic            overflow
);

  // Two extra digits: while the running value stays in W-bit range, one more
  // double-and-add step cannot leave this width, so overflow is seen exactly.
  localparam int RW = W + 2;
  localparam logic signed [RW-1:0] MAX_V = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_V = {3'b111, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, CONVERT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rs_q, rc_q;
  logic          mode_q;
  logic          accept;

  logic [RW-1:0] base_s, base_c, xp_ext, xm_inv;
  logic [RW-1:0] s1, maj1, c1, s2, maj2, c2;
  logic signed [RW-1:0] val_nxt;
  logic          ovf_nxt;
  logic [W-1:0]  conv;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = in_last ? CONVERT : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = CONVERT;
      end
      CONVERT: state_d = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Two 3:2 compressor rows: s+c+x_plus+~x_minus+1. The +1 rides in the free
  // LSB slot of the first carry row, so no carry chain touches the residue.
  always_comb begin
    xp_ext = {{(RW-BITS){1'b0}}, x_plus};
    xm_inv = ~{{(RW-BITS){1'b0}}, x_minus};
    base_s = '0;
    base_c = '0;
    if (state_q != IDLE) begin
      base_s = mode_q ? {rs_q[RW-2:0], 1'b0} : rs_q;
      base_c = mode_q ? {rc_q[RW-2:0], 1'b0} : rc_q;
    end
    s1      = base_s ^ base_c ^ xp_ext;
    maj1    = (base_s & base_c) | (base_s & xp_ext) | (base_c & xp_ext);
    c1      = {maj1[RW-2:0], 1'b1};
    s2      = s1 ^ c1 ^ xm_inv;
    maj2    = (s1 & c1) | (s1 & xm_inv) | (c1 & xm_inv);
    c2      = {maj2[RW-2:0], 1'b0};
    val_nxt = $signed(s2 + c2);
    ovf_nxt = (val_nxt > MAX_V) || (val_nxt < MIN_V);
    conv    = rs_q[W-1:0] + rc_q[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q     <= '0;
      rc_q     <= '0;
      mode_q   <= 1'b0;
      overflow <= 1'b0;
      result   <= '0;
      compare  <= 1'b0;
    end else begin
      if (accept) begin
        rs_q <= s2;
        rc_q <= c2;
        if (state_q == IDLE) begin
          mode_q   <= acc_mode;
          overflow <= ovf_nxt;
        end else begin
          overflow <= overflow | ovf_nxt;
        end
      end
      if (state_q == CONVERT) begin
        result  <= conv;
        compare <= conv[W-1];
      end
    end
  end

endmodule

// File: tb/tb_sd_stream_residue_accumulator.sv
// Directed bench for sd_stream_residue_accumulator (BITS=8, GUARD=4); expected results queued, checked by monitor.
module tb_sd_stream_residue_accumulator;
  localparam int BITS = 8;
  localparam int W    = 12;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cmp;
    logic         ovf;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic            acc_mode;
  logic [BITS-1:0] x_plus;
  logic [BITS-1:0] x_minus;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    result;
  logic            compare;
  logic            overflow;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  sd_stream_residue_accumulator #(.BITS(BITS), .GUARD(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .acc_mode(acc_mode), .x_plus(x_plus), .x_minus(x_minus),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .compare(compare), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [W-1:0] r, input logic c, input logic o);
    exp_t e;
    e.res = r;
    e.cmp = c;
    e.ovf = o;
    sb_q.push_back(e);
  endtask

  // Present a beat, wait for acceptance; on a last beat also check output timing.
  task automatic send(input logic [BITS-1:0] p, input logic [BITS-1:0] m,
                      input logic last, input logic mode);
    in_valid = 1'b1;
    x_plus   = p;
    x_minus  = m;
    in_last  = last;
    acc_mode = mode;
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (last) begin
      chk("lat_out_valid_after_accept", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("lat_out_valid_next_edge", {31'd0, out_valid}, 32'd1);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && !(in_ready && !out_valid); i++) begin
      @(posedge clk); #1;
    end
    if (!(in_ready && !out_valid)) chk("idle_timeout", {31'd0, out_valid}, 32'd0);
  endtask

  // Monitor: every output handshake pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", result, 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("result",   {20'd0, result},    {20'd0, e.res});
          chk("compare",  {31'd0, compare},  {31'd0, e.cmp});
          chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; acc_mode = 1'b0;
    x_plus = '0; x_minus = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    {20'd0, result},    32'd0);
    chk("rst_compare",   {31'd0, compare},   32'd0);
    chk("rst_overflow",  {31'd0, overflow},  32'd0);

    // plain sum, positive
    push(12'h00A, 1'b0, 1'b0);
    send(8'd5, 8'd0, 1'b0, 1'b0);
    send(8'd0, 8'd3, 1'b0, 1'b0);
    send(8'd10, 8'd2, 1'b1, 1'b0);
    wait_idle();

    // plain sum, negative
    push(12'hED4, 1'b1, 1'b0);
    send(8'd0, 8'd200, 1'b0, 1'b0);
    send(8'd0, 8'd100, 1'b1, 1'b0);
    wait_idle();

    // doubling mode; later acc_mode values ignored
    push(12'h003, 1'b0, 1'b0);
    send(8'd1, 8'd0, 1'b0, 1'b1);
    send(8'd0, 8'd1, 1'b0, 1'b0);
    send(8'd1, 8'd0, 1'b1, 1'b0);
    wait_idle();

    // overlapping plus/minus bits cancel: (240-255) + (15-15) = -15
    push(12'hFF1, 1'b1, 1'b0);
    send(8'hF0, 8'hFF, 1'b0, 1'b0);
    send(8'h0F, 8'h0F, 1'b1, 1'b0);
    wait_idle();

    // 9 x 255 = 2295 overflows; next transaction clears the flag
    push(12'h8F7, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) send(8'd255, 8'd0, (i == 8), 1'b0);
    wait_idle();
    push(12'h001, 1'b0, 1'b0);
    send(8'd1, 8'd0, 1'b1, 1'b0);
    wait_idle();

    // backpressure in HOLD with a pending beat: 3 - 5 = -2
    out_ready = 1'b0;
    push(12'hFFE, 1'b1, 1'b0);
    send(8'd3, 8'd0, 1'b0, 1'b0);
    send(8'd0, 8'd5, 1'b1, 1'b0);
    in_valid = 1'b1; x_plus = 8'd4; x_minus = 8'd0; in_last = 1'b1; acc_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result",    {20'd0, result},    32'hFFE);
      chk("bp_compare",   {31'd0, compare},   32'd1);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_after_hs_in_ready",  {31'd0, in_ready},  32'd1);
    push(12'h004, 1'b0, 1'b0);
    send(8'd4, 8'd0, 1'b1, 1'b0);
    wait_idle();

    // reset mid-accumulation after overflow was flagged (255,765,1785,3825)
    for (int i = 0; i < 4; i++) send(8'd255, 8'd0, 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_overflow",  {31'd0, overflow},  32'd0);
    chk("midrst_result",    {20'd0, result},    32'd0);
    push(12'h007, 1'b0, 1'b0);
    send(8'd7, 8'd0, 1'b1, 1'b0);
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
